// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register specifiers and status codes.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

endpackage

// File: rtl/regfile_2r2w.sv
// 15-entry program register file: two combinational read ports, a debug read
// port, and two write ports (E and M) where M wins on a shared destination.
module regfile_2r2w
    import y86_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_RSP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        dbg_idx,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [DATA_W-1:0] dbg_val
);

    logic [DATA_W-1:0] regs [0:14];

    // Specifier F means "no register" and always reads as zero.
    function automatic logic [DATA_W-1:0] rd(input logic [3:0] idx);
        return (idx == RNONE) ? '0 : regs[idx];
    endfunction

    assign valA    = rd(srcA);
    assign valB    = rd(srcB);
    assign dbg_val = rd(dbg_idx);

    // NOTE: the array is architectural state that must read as defined values
    // after reset, so every entry is reset explicitly rather than left to RAM init.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= '0;
            regs[RRSP] <= RESET_RSP;
        end else if (we) begin
            // NOTE: non-blocking writes; the M write is issued last so it
            // overrides E when both target the same register.
            if (dstE != RNONE)
                regs[dstE] <= valE;
            if (dstM != RNONE)
                regs[dstM] <= valM;
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode/write-back stage with sticky halt. Define DECODE_PERF_CNT_EN to add
// the retired_cnt and halt_cycles performance counters.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_RSP = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        stat,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic              halted,
    input  logic [3:0]        dbg_idx,
`ifdef DECODE_PERF_CNT_EN
    output logic [63:0]       retired_cnt,
    output logic [63:0]       halt_cycles,
`endif
    output logic [DATA_W-1:0] dbg_val
);

    logic [3:0] srcA;
    logic [3:0] srcB;
    logic       retire;

    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        unique case (icode)
            IRRMOVQ: begin srcA = rA; dstE = cnd ? rB : RNONE; end
            IIRMOVQ: dstE = rB;
            IRMMOVQ: begin srcA = rA; srcB = rB; end
            IMRMOVQ: begin srcB = rB; dstM = rA; end
            IOPQ:    begin srcA = rA; srcB = rB; dstE = rB; end
            ICALL:   begin srcB = RRSP; dstE = RRSP; end
            IRET:    begin srcA = RRSP; srcB = RRSP; dstE = RRSP; end
            IPUSHQ:  begin srcA = rA; srcB = RRSP; dstE = RRSP; end
            IPOPQ:   begin srcA = RRSP; srcB = RRSP; dstE = RRSP; dstM = rA; end
            default: ;
        endcase
    end

    // Architectural state only advances for a good instruction while running.
    assign retire = !halted && (stat == SAOK);

    always_ff @(posedge clk) begin
        if (rst)
            halted <= 1'b0;
        else if (stat != SAOK)
            halted <= 1'b1;
    end

`ifdef DECODE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
            halt_cycles <= '0;
        end else begin
            if (retire)
                retired_cnt <= retired_cnt + 64'd1;
            if (halted)
                halt_cycles <= halt_cycles + 64'd1;
        end
    end
`endif

    regfile_2r2w #(
        .DATA_W    (DATA_W),
        .RESET_RSP (RESET_RSP)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (retire),
        .srcA    (srcA),
        .srcB    (srcB),
        .dstE    (dstE),
        .dstM    (dstM),
        .valE    (valE),
        .valM    (valM),
        .dbg_idx (dbg_idx),
        .valA    (valA),
        .valB    (valB),
        .dbg_val (dbg_val)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: decode, register writes, M priority,
// halt freeze and reset. Covers retired_cnt/halt_cycles when DECODE_PERF_CNT_EN is set.
module tb_decode_writeback;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode, rA, rB, stat, dbg_idx, dstE, dstM;
    logic        cnd, halted;
    logic [63:0] valE, valM, valA, valB, dbg_val;
`ifdef DECODE_PERF_CNT_EN
    logic [63:0] retired_cnt, halt_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_writeback #(.DATA_W(64), .RESET_RSP(64'h200)) dut (
        .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .stat(stat), .valA(valA), .valB(valB),
        .dstE(dstE), .dstM(dstM), .halted(halted), .dbg_idx(dbg_idx),
`ifdef DECODE_PERF_CNT_EN
        .retired_cnt(retired_cnt), .halt_cycles(halt_cycles),
`endif
        .dbg_val(dbg_val)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_is(input logic [3:0] idx, input logic [63:0] exp, input string tag);
        dbg_idx = idx;
        #1;
        check(tag, dbg_val, exp);
    endtask

    initial begin
        rst = 1'b1; icode = INOP; rA = RNONE; rB = RNONE; cnd = 1'b0;
        valE = '0; valM = '0; stat = SAOK; dbg_idx = 4'h0;

        // Reset state
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++)
            reg_is(4'(i), (i == 4) ? 64'h200 : 64'h0, $sformatf("reset_reg%0d", i));
        reg_is(4'hF, 64'h0, "dbg_none");
        check("reset_halted", {63'b0, halted}, 64'h0);

        // irmovq $0x10, %rdx
        icode = IIRMOVQ; rA = RNONE; rB = 4'h2; valE = 64'h10; #1;
        check("irmovq_dstE", {60'b0, dstE}, 64'h2);
        check("irmovq_dstM", {60'b0, dstM}, 64'hF);
        step();
        reg_is(4'h2, 64'h10, "irmovq_reg2");

        // OPq %rdx, %rdx: operands are pre-edge values, no bypass
        icode = IOPQ; rA = 4'h2; rB = 4'h2; valE = 64'h20; #1;
        check("opq_valA", valA, 64'h10);
        check("opq_valB", valB, 64'h10);
        check("opq_dstE", {60'b0, dstE}, 64'h2);
        step();
        check("opq_valA_after", valA, 64'h20);

        // cmovXX not taken, then taken
        icode = IRRMOVQ; rA = 4'h1; rB = 4'h3; cnd = 1'b0; valE = 64'h5; #1;
        check("cmov_nt_dstE", {60'b0, dstE}, 64'hF);
        step();
        reg_is(4'h3, 64'h0, "cmov_nt_reg3");
        cnd = 1'b1; #1;
        check("cmov_t_dstE", {60'b0, dstE}, 64'h3);
        step();
        reg_is(4'h3, 64'h5, "cmov_t_reg3");
        cnd = 1'b0;

        // popq %rsp: M wins over E
        icode = IPOPQ; rA = RRSP; rB = RNONE; valE = 64'h208; valM = 64'hABCD; #1;
        check("popq_valA", valA, 64'h200);
        check("popq_valB", valB, 64'h200);
        check("popq_dstE", {60'b0, dstE}, 64'h4);
        check("popq_dstM", {60'b0, dstM}, 64'h4);
        step();
        reg_is(4'h4, 64'hABCD, "popq_reg4");

        // pushq %rdx decode only
        icode = IPUSHQ; rA = 4'h2; rB = RNONE; #1;
        check("pushq_valA", valA, 64'h20);
        check("pushq_valB", valB, 64'hABCD);
        check("pushq_dstE", {60'b0, dstE}, 64'h4);
        check("pushq_dstM", {60'b0, dstM}, 64'hF);

        // mrmovq 0(%rdx), %rsi
        icode = IMRMOVQ; rA = 4'h6; rB = 4'h2; valM = 64'h77; #1;
        check("mrmovq_valB", valB, 64'h20);
        check("mrmovq_dstE", {60'b0, dstE}, 64'hF);
        check("mrmovq_dstM", {60'b0, dstM}, 64'h6);
        step();
        reg_is(4'h6, 64'h77, "mrmovq_reg6");

        // Undefined icode: no sources or destinations
        icode = 4'hC; rA = 4'h2; rB = 4'h2; #1;
        check("undef_dstE", {60'b0, dstE}, 64'hF);
        check("undef_dstM", {60'b0, dstM}, 64'hF);
        check("undef_valA", valA, 64'h0);
        check("undef_valB", valB, 64'h0);

        // Halt, then writes are frozen
        icode = IHALT; rA = RNONE; rB = RNONE; stat = SHLT;
        step();
        check("halt_set", {63'b0, halted}, 64'h1);
        icode = IIRMOVQ; rB = 4'h1; valE = 64'h7; stat = SAOK;
        step();
        step();
        reg_is(4'h1, 64'h0, "halt_freeze_reg1");
        check("halt_sticky", {63'b0, halted}, 64'h1);
`ifdef DECODE_PERF_CNT_EN
        check("perf_retired", retired_cnt, 64'd6);
        check("perf_halt_cycles", halt_cycles, 64'd2);
`endif

        // Reset overrides a simultaneous write
        rst = 1'b1; icode = IIRMOVQ; rB = 4'h5; valE = 64'h9; stat = SAOK;
        step();
        rst = 1'b0; icode = INOP; rB = RNONE;
        check("rst_halted", {63'b0, halted}, 64'h0);
        reg_is(4'h5, 64'h0, "rst_reg5");
        reg_is(4'h4, 64'h200, "rst_reg4");
        reg_is(4'h2, 64'h0, "rst_reg2");
`ifdef DECODE_PERF_CNT_EN
        check("rst_retired", retired_cnt, 64'd0);
        check("rst_halt_cycles", halt_cycles, 64'd0);
`endif

        // Writes resume after reset
        icode = IIRMOVQ; rB = 4'h1; valE = 64'h7;
        step();
        reg_is(4'h1, 64'h7, "resume_reg1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
